// File: rtl/whack_game_if.sv
// Signal bundle between the whack-a-mole controller and its surroundings:
// the buttons, the BCD countdown timer, the LED bank and the score display.
interface whack_game_if;
    logic       start;
    logic [7:0] hit;
    logic [3:0] tens_digit;
    logic [3:0] ones_digit;
    logic       timer_load;
    logic [3:0] load_tens_digit;
    logic [3:0] load_ones_digit;
    logic [7:0] mole;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic       playing;
    logic       game_over;

    modport master (
        output start, hit, tens_digit, ones_digit,
        input  timer_load, load_tens_digit, load_ones_digit,
        input  mole, score_tens, score_ones, playing, game_over
    );

    modport slave (
        input  start, hit, tens_digit, ones_digit,
        output timer_load, load_tens_digit, load_ones_digit,
        output mole, score_tens, score_ones, playing, game_over
    );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game flow: loads the countdown timer, lights one random mole at
// a time, scores hits in saturating BCD and stops when the timer reads 00.
module whack_game_ctrl #(
    parameter logic [3:0]  GAME_TENS  = 4'd6,
    parameter logic [3:0]  GAME_ONES  = 4'd0,
    parameter int          MOLE_TICKS = 50_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    whack_game_if.slave game_bus
);
    localparam int               CNT_W    = $clog2(MOLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOLE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_SPAWN, S_UP, S_OVER
    } state_t;

    state_t           r_state;
    logic [15:0]      r_lfsr;
    logic [CNT_W-1:0] r_mole_cnt;
    logic [2:0]       r_prev_idx;
    logic [7:0]       r_mole;
    logic [3:0]       r_score_tens;
    logic [3:0]       r_score_ones;
    logic             r_timer_load;
    logic             r_playing;
    logic             r_game_over;

    logic       w_lfsr_fb;
    logic       w_time_up;
    logic       w_hit_lit;
    logic       w_in_play;
    logic [2:0] w_lfsr_idx;
    logic [2:0] w_spawn_idx;
    logic [3:0] w_inc_tens;
    logic [3:0] w_inc_ones;

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_time_up   = (game_bus.tens_digit == 4'd0) && (game_bus.ones_digit == 4'd0);
    assign w_hit_lit   = |(game_bus.hit & r_mole);
    assign w_in_play   = (r_state == S_ARM) || (r_state == S_SPAWN) || (r_state == S_UP);
    assign w_lfsr_idx  = r_lfsr[2:0];
    // Never relight the same hole twice in a row: step to the next one instead.
    assign w_spawn_idx = (w_lfsr_idx == r_prev_idx) ? w_lfsr_idx + 3'd1 : w_lfsr_idx;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_inc_tens = r_score_tens;
        w_inc_ones = r_score_ones;
        if (!(r_score_tens == 4'd9 && r_score_ones == 4'd9)) begin
            if (r_score_ones == 4'd9) begin
                w_inc_ones = 4'd0;
                w_inc_tens = r_score_tens + 4'd1;
            end else begin
                w_inc_ones = r_score_ones + 4'd1;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_mole_cnt   <= '0;
            r_prev_idx   <= 3'd0;
            r_mole       <= 8'h00;
            r_score_tens <= 4'd0;
            r_score_ones <= 4'd0;
            r_timer_load <= 1'b0;
            r_playing    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
            r_timer_load <= 1'b0;

            // Time-out beats everything else, including a hit in the same cycle.
            if (w_in_play && w_time_up) begin
                r_state     <= S_OVER;
                r_mole      <= 8'h00;
                r_playing   <= 1'b0;
                r_game_over <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (game_bus.start) begin
                            r_state      <= S_LOAD;
                            r_timer_load <= 1'b1;
                            r_score_tens <= 4'd0;
                            r_score_ones <= 4'd0;
                        end
                    end
                    S_LOAD: begin
                        r_state      <= S_ARM;
                        r_playing    <= 1'b1;
                        r_score_tens <= 4'd0;
                        r_score_ones <= 4'd0;
                    end
                    S_ARM: begin
                        r_state <= S_SPAWN;
                    end
                    S_SPAWN: begin
                        r_state    <= S_UP;
                        r_mole     <= 8'h01 << w_spawn_idx;
                        r_prev_idx <= w_spawn_idx;
                        r_mole_cnt <= '0;
                    end
                    S_UP: begin
                        if (w_hit_lit) begin
                            r_state      <= S_SPAWN;
                            r_mole       <= 8'h00;
                            r_score_tens <= w_inc_tens;
                            r_score_ones <= w_inc_ones;
                        end else if (r_mole_cnt == CNT_LAST) begin
                            r_state <= S_SPAWN;
                            r_mole  <= 8'h00;
                        end else begin
                            r_mole_cnt <= r_mole_cnt + 1'b1;
                        end
                    end
                    S_OVER: begin
                        if (game_bus.start) begin
                            r_state      <= S_LOAD;
                            r_timer_load <= 1'b1;
                            r_game_over  <= 1'b0;
                            r_score_tens <= 4'd0;
                            r_score_ones <= 4'd0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign game_bus.timer_load      = r_timer_load;
    assign game_bus.load_tens_digit = GAME_TENS;
    assign game_bus.load_ones_digit = GAME_ONES;
    assign game_bus.mole            = r_mole;
    assign game_bus.score_tens      = r_score_tens;
    assign game_bus.score_ones      = r_score_ones;
    assign game_bus.playing         = r_playing;
    assign game_bus.game_over       = r_game_over;
endmodule
